// File: rtl/equalize_output.sv
// Histogram equalizer output stage: builds a 256-entry LUT from the CDF,
// then streams the source image through it into the output memory.
module equalize_output #(
    parameter logic [14:0] ADDRESS_OF_LAST = 15'd3,
    parameter logic [19:0] TOTAL_PIXELS    = 20'd64
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         start,
    input  logic         inputBaseOffset,
    input  logic [19:0]  cdf_min,
    input  logic [35:0]  m2ReadBus,
    input  logic [127:0] m3ReadBus,
    output logic [15:0]  m2ReadAddr,
    output logic [15:0]  m3ReadAddr,
    output logic [15:0]  m4WriteAddr,
    output logic [127:0] m4WriteBus,
    output logic         m4WE,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE, CDF_REQ, CDF_WAIT, DIVIDE, STORE, MAP, DRAIN, DONE
    } state_t;

    state_t        state_q;
    logic [7:0]    v_q;
    logic [19:0]   prev_q;
    logic [19:0]   cmin_q;
    logic [19:0]   den_q;
    logic [19:0]   rem_q;
    logic [27:0]   quo_q;
    logic [4:0]    cnt_q;
    logic [14:0]   word_q;
    logic          rd_vld_q;
    logic [15:0]   rd_addr_q;
    logic [7:0]    lut_q [256];

    logic [19:0]   cdf_w;
    logic [19:0]   diff_w;
    logic [27:0]   num_w;
    logic [20:0]   rem_sh;
    logic          ge_w;
    logic [7:0]    lut_wd;
    logic [127:0]  map_w;

    always_comb begin
        cdf_w  = (m2ReadBus[35:20] == 16'hAAAA) ? m2ReadBus[19:0] : prev_q;
        diff_w = cdf_w - cmin_q;
        num_w  = '0;
        if (cdf_w >= cmin_q)
            num_w = {8'd0, diff_w} * 28'd255 + {8'd0, den_q >> 1};
        rem_sh = {rem_q, quo_q[27]};
        ge_w   = rem_sh >= {1'b0, den_q};
        // Zero divisor yields all-ones quotient; force it to black instead
        lut_wd = quo_q[7:0];
        if (den_q == 20'd0)
            lut_wd = 8'd0;
        else if (|quo_q[27:8])
            lut_wd = 8'hFF;
    end

    always_comb begin
        map_w = '0;
        for (int k = 0; k < 16; k++)
            map_w[8*k +: 8] = lut_q[m3ReadBus[8*k +: 8]];
    end

    always_ff @(posedge clock) begin
        if (state_q == STORE)
            lut_q[v_q] <= lut_wd;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            v_q         <= '0;
            prev_q      <= '0;
            cmin_q      <= '0;
            den_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            m2ReadAddr  <= '0;
            m3ReadAddr  <= '0;
            m4WriteAddr <= '0;
            m4WriteBus  <= '0;
            m4WE        <= 1'b0;
            done        <= 1'b0;
        end else if (state_q != IDLE && !start) begin
            // Abort: squash the pipeline so nothing writes after this edge
            state_q     <= IDLE;
            rd_vld_q    <= 1'b0;
            m2ReadAddr  <= '0;
            m3ReadAddr  <= '0;
            m4WriteAddr <= '0;
            m4WriteBus  <= '0;
            m4WE        <= 1'b0;
            done        <= 1'b0;
        end else begin
            m4WE      <= rd_vld_q;
            rd_vld_q  <= (state_q == MAP);
            rd_addr_q <= m3ReadAddr;
            if (rd_vld_q) begin
                m4WriteAddr <= rd_addr_q;
                m4WriteBus  <= map_w;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cmin_q     <= cdf_min;
                        den_q      <= TOTAL_PIXELS - cdf_min;
                        v_q        <= '0;
                        prev_q     <= '0;
                        m2ReadAddr <= '0;
                        state_q    <= CDF_REQ;
                    end
                end
                CDF_REQ: state_q <= CDF_WAIT;
                CDF_WAIT: begin
                    prev_q  <= cdf_w;
                    quo_q   <= num_w;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= DIVIDE;
                end
                DIVIDE: begin
                    rem_q <= ge_w ? 20'(rem_sh - {1'b0, den_q})
                                  : rem_sh[19:0];
                    quo_q <= {quo_q[26:0], ge_w};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd27)
                        state_q <= STORE;
                end
                STORE: begin
                    if (v_q == 8'd255) begin
                        word_q     <= '0;
                        m3ReadAddr <= {inputBaseOffset, 15'd0};
                        state_q    <= MAP;
                    end else begin
                        v_q        <= v_q + 8'd1;
                        m2ReadAddr <= {8'h00, 8'(v_q + 8'd1)};
                        state_q    <= CDF_REQ;
                    end
                end
                MAP: begin
                    if (word_q == ADDRESS_OF_LAST) begin
                        cnt_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        word_q     <= word_q + 15'd1;
                        m3ReadAddr <= {inputBaseOffset,
                                       15'(word_q + 15'd1)};
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd1) begin
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: done <= 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_equalize_output.sv
// Directed bench for equalize_output: ramp, constant, two-value,
// abort, async reset and upper-bank addressing runs.
module tb_equalize_output;

    logic         clock = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         inputBaseOffset = 1'b0;
    logic [19:0]  cdf_min = '0;
    logic [35:0]  m2ReadBus = '0;
    logic [127:0] m3ReadBus = '0;
    logic [15:0]  m2ReadAddr;
    logic [15:0]  m3ReadAddr;
    logic [15:0]  m4WriteAddr;
    logic [127:0] m4WriteBus;
    logic         m4WE;
    logic         done;

    logic [35:0]  m2mem [256];
    logic [127:0] m3mem [4];
    logic [15:0]  wr_addr [8];
    logic [127:0] wr_data [8];
    int           wr_n = 0;
    int           nchk = 0;
    int           nerr = 0;

    localparam logic [127:0] ALT = 128'hFF00FF00FF00FF00FF00FF00FF00FF00;

    equalize_output dut (
        .clock(clock),
        .rst_n(rst_n),
        .start(start),
        .inputBaseOffset(inputBaseOffset),
        .cdf_min(cdf_min),
        .m2ReadBus(m2ReadBus),
        .m3ReadBus(m3ReadBus),
        .m2ReadAddr(m2ReadAddr),
        .m3ReadAddr(m3ReadAddr),
        .m4WriteAddr(m4WriteAddr),
        .m4WriteBus(m4WriteBus),
        .m4WE(m4WE),
        .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        m2ReadBus <= m2mem[m2ReadAddr[7:0]];
        m3ReadBus <= m3mem[m3ReadAddr[1:0]];
    end

    always @(negedge clock) begin
        if (m4WE) begin
            if (wr_n < 8) begin
                wr_addr[wr_n] = m4WriteAddr;
                wr_data[wr_n] = m4WriteBus;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ramp_word(input int w);
        logic [127:0] r;
        int p, q;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            p = 16 * w + k;
            q = (p * 255 + 31) / 63;
            if (q > 255) q = 255;
            r[8*k +: 8] = 8'(q);
        end
        return r;
    endfunction

    task automatic load_ramp();
        for (int v = 0; v < 256; v++)
            m2mem[v] = {16'hAAAA, 20'(v < 64 ? v + 1 : 64)};
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 16; k++)
                m3mem[w][8*k +: 8] = 8'(16 * w + k);
    endtask

    task automatic load_const();
        for (int v = 0; v < 256; v++)
            m2mem[v] = {16'hAAAA, 20'(v < 8'h50 ? 0 : 64)};
        for (int w = 0; w < 4; w++)
            m3mem[w] = {16{8'h50}};
    endtask

    task automatic load_two();
        for (int v = 0; v < 256; v++) begin
            if (v < 10)       m2mem[v] = {16'hAAAA, 20'd0};
            else if (v == 10) m2mem[v] = {16'hAAAA, 20'd32};
            else if (v < 200) m2mem[v] = {16'h5555, 20'hFFFFF};
            else if (v == 200) m2mem[v] = {16'hAAAA, 20'd64};
            else              m2mem[v] = {16'h1234, 20'd7};
        end
        for (int w = 0; w < 4; w++)
            m3mem[w] = {8{8'd200, 8'd10}};
        m3mem[3][119:112] = 8'd150;
        m3mem[3][127:120] = 8'd230;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_m2a"}, 128'(m2ReadAddr), 128'd0);
        chk({tag, "_m3a"}, 128'(m3ReadAddr), 128'd0);
        chk({tag, "_m4a"}, 128'(m4WriteAddr), 128'd0);
        chk({tag, "_m4d"}, m4WriteBus, 128'd0);
        chk({tag, "_we"}, 128'(m4WE), 128'd0);
        chk({tag, "_done"}, 128'(done), 128'd0);
    endtask

    task automatic run(input logic ibo, input logic [19:0] cmin);
        int cyc;
        bit seen;
        @(negedge clock);
        wr_n = 0;
        inputBaseOffset = ibo;
        cdf_min = cmin;
        start = 1'b1;
        cyc = 0;
        seen = 0;
        while (!done && cyc < 9000) begin
            @(negedge clock);
            cyc++;
            if (cyc == 94)
                chk("m2addr_v3", 128'(m2ReadAddr), 128'h0003);
            if (m4WE && !seen) begin
                seen = 1;
                chk("m3addr_w2", 128'(m3ReadAddr), 128'({ibo, 15'd2}));
            end
        end
        chk("latency", 128'(cyc), 128'd7943);
        chk("n_writes", 128'(wr_n), 128'd4);
        for (int i = 0; i < 4; i++)
            chk("wr_addr", 128'(wr_addr[i]), 128'({ibo, 15'(i)}));
        start = 1'b0;
        @(negedge clock);
        chk("done_clr", 128'(done), 128'd0);
    endtask

    task automatic check_ramp_words(input string tag);
        for (int w = 0; w < 4; w++)
            chk(tag, wr_data[w], ramp_word(w));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        load_ramp();
        run(1'b0, 20'd1);
        check_ramp_words("ramp_word");
        chk("lut1", 128'(wr_data[0][15:8]), 128'd4);
        chk("lut32", 128'(wr_data[2][7:0]), 128'd130);
        chk("lut63", 128'(wr_data[3][127:120]), 128'd255);

        load_const();
        run(1'b0, 20'd64);
        for (int w = 0; w < 4; w++)
            chk("const_word", wr_data[w], 128'd0);

        load_two();
        run(1'b0, 20'd32);
        for (int w = 0; w < 4; w++)
            chk("two_word", wr_data[w], ALT);

        // Abort after the second write, then rerun
        load_ramp();
        @(negedge clock);
        wr_n = 0;
        inputBaseOffset = 1'b0;
        cdf_min = 20'd1;
        start = 1'b1;
        n = 0;
        begin
            int seen_we;
            seen_we = 0;
            while (seen_we < 2 && n < 9000) begin
                @(negedge clock);
                n++;
                if (m4WE) seen_we++;
            end
            chk("abort_reach", 128'(seen_we), 128'd2);
        end
        start = 1'b0;
        @(negedge clock);
        check_outputs_zero("abort");
        repeat (20) @(negedge clock);
        chk("abort_nwr", 128'(wr_n), 128'd2);
        chk("abort_done", 128'(done), 128'd0);
        run(1'b0, 20'd1);
        check_ramp_words("rerun_word");

        // Async reset in the middle of a divide
        @(negedge clock);
        cdf_min = 20'd1;
        start = 1'b1;
        repeat (104) @(negedge clock);
        chk("pre_rst_m2a", 128'(m2ReadAddr), 128'h0003);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async");
        start = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        run(1'b1, 20'd1);
        check_ramp_words("hi_word");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
